// File: rtl/rst_sync_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_sync_seq_pkg
//   Shared definitions for the staged reset sequencer:
//     - state_t     : sequencer FSM encoding (3 bits, also exported for debug)
//     - SW_CNT_W    : width of the accepted software-reset counter
//     - SW_CNT_MAX  : saturation value of that counter
//     - max3()      : largest of three integers (counter sizing)
//     - cnt_width() : bits needed to count 0..max_val-1 (never below 1)
// -----------------------------------------------------------------------------
package rst_sync_seq_pkg;

  localparam int SW_CNT_W = 8;
  localparam logic [SW_CNT_W-1:0] SW_CNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,  // waiting for the synchronized release of rst_n_i
    ST_HOLD  = 3'd1,  // all outputs asserted, counting the hold period
    ST_REL   = 3'd2,  // releasing stages one by one
    ST_RUN   = 3'd3,  // all stages released, ready
    ST_SWRST = 3'd4   // software-requested reset in progress
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counters only ever hold values 0..max_val-1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/rst_sync_seq_sync_cell.sv
// -----------------------------------------------------------------------------
// rst_sync_cell
//   Reset-deassertion synchronizer. A chain of NR_SYNC flops, asynchronously
//   cleared by rst_n and shifting in a constant 1. The output rises NR_SYNC
//   clock edges after rst_n is released, which gives any metastable first
//   stage a full cycle to settle. This is the only logic that observes the raw
//   deassertion of the board reset.
// Ports:
//   clk     in   1  system clock
//   rst_n   in   1  raw asynchronous active-low reset
//   sync_o  out  1  synchronized release, 1 once rst_n has been high NR_SYNC edges
// -----------------------------------------------------------------------------
module rst_sync_cell #(
  parameter int NR_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_o
);

  logic [NR_SYNC-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[NR_SYNC-2:0], 1'b1};
    end
  end

  assign sync_o = chain_q[NR_SYNC-1];

endmodule

// File: rtl/rst_sync_seq.sv
// -----------------------------------------------------------------------------
// rst_sync_seq
//   Staged reset sequencer for the intersection controller. Takes the raw
//   clock and asynchronous active-low reset and produces NR_STAGES reset
//   outputs that assert asynchronously and release synchronously, bit 0 first
//   (timers), then the FSM, then the light drivers, STAGE_GAP cycles apart.
//   A software reset request taken in ST_RUN re-asserts every output for
//   SW_RST_CYCLES cycles and then replays the hold/release sequence without
//   re-running the synchronizer.
// Ports:
//   clk_i         in   1          system clock, all logic on posedge
//   rst_n_i       in   1          asynchronous active-low reset
//   sw_rst_req_i  in   1          software reset request, level sampled on posedge
//   rst_n_o       out  NR_STAGES  staged resets, active-low, bit k released k-th
//   ready_o       out  1          1 when every rst_n_o bit is released
//   sw_rst_cnt_o  out  8          accepted software resets, saturating at 255
//   state_o       out  3          current sequencer state (debug observation)
// Handshake: sw_rst_req_i is a plain level with no acknowledge; it is acted on
//   only in a cycle where the sequencer is in ST_RUN (ready_o=1 before the
//   edge). Requests in any other state are dropped, not queued or counted.
// All outputs come straight from flops; rst_n_i reaches them only through the
// asynchronous clear.
// -----------------------------------------------------------------------------
module rst_sync_seq
  import rst_sync_seq_pkg::*;
#(
  parameter int NR_SYNC       = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int NR_STAGES     = 3,
  parameter int STAGE_GAP     = 2,
  parameter int SW_RST_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sw_rst_req_i,
  output logic [NR_STAGES-1:0] rst_n_o,
  output logic                 ready_o,
  output logic [SW_CNT_W-1:0]  sw_rst_cnt_o,
  output logic [2:0]           state_o
);

  // One shared cycle counter serves the hold, gap and software-reset periods.
  localparam int CNT_MAX = max3(HOLD_CYCLES, STAGE_GAP * NR_STAGES, SW_RST_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int STG_W   = cnt_width(NR_STAGES);

  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]    SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [STG_W-1:0]    STG_ONE   = STG_W'(1);
  localparam logic [STG_W-1:0]    STG_LAST  = STG_W'(NR_STAGES - 1);
  localparam logic [SW_CNT_W-1:0] SW_ONE    = SW_CNT_W'(1);

  logic sync;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STG_W-1:0]      stg_q, stg_d;    // index of the next stage to release
  logic [NR_STAGES-1:0]  rst_n_q, rst_n_d;
  logic                  ready_q, ready_d;
  logic [SW_CNT_W-1:0]   sw_cnt_q, sw_cnt_d;
  logic                  release_first;
  logic                  release_next;

  rst_sync_cell #(
    .NR_SYNC (NR_SYNC)
  ) u_sync (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .sync_o (sync)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stg_d         = stg_q;
    rst_n_d       = rst_n_q;
    ready_d       = ready_q;
    sw_cnt_d      = sw_cnt_q;
    release_first = 1'b0;
    release_next  = 1'b0;

    unique case (state_q)
      // The edge that first sees sync=1 already counts as hold cycle one, so
      // bit 0 rises exactly NR_SYNC+HOLD_CYCLES edges after the release.
      ST_RST: begin
        if (sync) begin
          if (HOLD_CYCLES == 1) begin
            release_first = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CNT_ONE;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          release_first = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_REL: begin
        if (cnt_q == GAP_LAST) begin
          release_next = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (sw_rst_req_i) begin
          state_d = ST_SWRST;
          cnt_d   = '0;
          rst_n_d = '0;
          ready_d = 1'b0;
          if (sw_cnt_q != SW_CNT_MAX) begin
            sw_cnt_d = sw_cnt_q + SW_ONE;
          end
        end
      end

      // Leaving at the SW_RST_CYCLES-th edge with cnt=0 means the hold period
      // that follows is a full HOLD_CYCLES edges (no synchronizer edge to fold in).
      ST_SWRST: begin
        if (cnt_q == SW_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase

    if (release_first) begin
      rst_n_d    = '0;
      rst_n_d[0] = 1'b1;
      cnt_d      = '0;
      stg_d      = STG_ONE;
      if (NR_STAGES == 1) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        state_d = ST_REL;
      end
    end

    // Shifting a 1 in from bit 0 keeps the vector thermometer-coded.
    if (release_next) begin
      for (int i = NR_STAGES - 1; i > 0; i--) begin
        rst_n_d[i] = rst_n_q[i-1];
      end
      rst_n_d[0] = 1'b1;
      cnt_d      = '0;
      if (stg_q == STG_LAST) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        stg_d = stg_q + STG_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      stg_q    <= '0;
      rst_n_q  <= '0;
      ready_q  <= 1'b0;
      sw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stg_q    <= stg_d;
      rst_n_q  <= rst_n_d;
      ready_q  <= ready_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  assign rst_n_o      = rst_n_q;
  assign ready_o      = ready_q;
  assign sw_rst_cnt_o = sw_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_sync_seq
//   Bench for rst_sync_seq. A reference model tracks, per posedge, the edge
//   number since the last reset release and the edge at which stage 0 is due;
//   stage k and ready follow from plain arithmetic on those numbers. Expected
//   outputs are pushed into exp_q at each posedge and a monitor pops and
//   compares them on the following negedge.
// -----------------------------------------------------------------------------
module tb_rst_sync_seq;

  localparam int NR_SYNC       = 2;
  localparam int HOLD_CYCLES   = 4;
  localparam int NR_STAGES     = 3;
  localparam int STAGE_GAP     = 2;
  localparam int SW_RST_CYCLES = 8;
  localparam int W             = NR_STAGES + 1 + 8;

  // clock / reset
  logic clk;
  logic rst_n_i;
  logic sw_rst_req_i;
  logic [NR_STAGES-1:0] rst_n_o;
  logic ready_o;
  logic [7:0] sw_rst_cnt_o;
  logic [2:0] state_o;

  initial clk = 1'b1;
  always #10 clk = ~clk;

  rst_sync_seq #(
    .NR_SYNC       (NR_SYNC),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .NR_STAGES     (NR_STAGES),
    .STAGE_GAP     (STAGE_GAP),
    .SW_RST_CYCLES (SW_RST_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .sw_rst_req_i (sw_rst_req_i),
    .rst_n_o      (rst_n_o),
    .ready_o      (ready_o),
    .sw_rst_cnt_o (sw_rst_cnt_o),
    .state_o      (state_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int rst_events = 0;   // bumped by the driver on every rst_n_i drop

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model
  int   seen_rst  = 0;
  int   edge_n    = 0;
  int   rel_edge  = NR_SYNC + HOLD_CYCLES;
  int   m_cnt     = 0;
  logic m_ready   = 1'b0;

  initial begin
    logic [NR_STAGES-1:0] exp_bits;
    forever begin
      @(posedge clk);
      if (rst_events != seen_rst || !rst_n_i) begin
        seen_rst = rst_events;
        edge_n   = 0;
        rel_edge = NR_SYNC + HOLD_CYCLES;
        m_cnt    = 0;
        m_ready  = 1'b0;
      end
      if (rst_n_i) begin
        edge_n++;
        if (m_ready && sw_rst_req_i) begin
          if (m_cnt < 255) m_cnt++;
          rel_edge = edge_n + SW_RST_CYCLES + HOLD_CYCLES;
        end
      end
      for (int k = 0; k < NR_STAGES; k++) begin
        exp_bits[k] = (edge_n >= rel_edge + k * STAGE_GAP);
      end
      m_ready = (edge_n >= rel_edge + (NR_STAGES - 1) * STAGE_GAP);
      exp_q.push_back({exp_bits, m_ready, 8'(m_cnt)});
    end
  end

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_rst_n", 32'(rst_n_o), 32'(e[W-1 -: NR_STAGES]));
        check("out_ready", 32'(ready_o), 32'(e[8]));
        check("out_sw_cnt", 32'(sw_rst_cnt_o), 32'(e[7:0]));
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input int n);
    @(negedge clk);
    #2 sw_rst_req_i = 1'b1;
    repeat (n) @(negedge clk);
    #2 sw_rst_req_i = 1'b0;
  endtask

  task automatic check_cleared(input string name);
    check({name, "_rst_n"}, 32'(rst_n_o), 32'd0);
    check({name, "_ready"}, 32'(ready_o), 32'd0);
    check({name, "_cnt"}, 32'(sw_rst_cnt_o), 32'd0);
  endtask

  // stimulus
  initial begin
    rst_n_i      = 1'b0;
    sw_rst_req_i = 1'b0;
    #50 rst_n_i = 1'b1;
    wait_cycles(14);
    check("powerup_rst_n", 32'(rst_n_o), 32'h7);
    check("powerup_ready", 32'(ready_o), 32'd1);

    // single one-cycle request
    pulse_req(1);
    wait_cycles(20);
    check("pulse_cnt", 32'(sw_rst_cnt_o), 32'd1);

    // randomized requests of random length and spacing
    for (int i = 0; i < 20; i++) begin
      wait_cycles($urandom_range(1, 25));
      pulse_req($urandom_range(1, 3));
    end
    wait_cycles(20);

    // asynchronous assertion mid-cycle while running
    @(negedge clk);
    #3 rst_n_i = 1'b0;
    rst_events++;
    #1 check_cleared("async");
    repeat (2) @(negedge clk);
    #5 rst_n_i = 1'b1;
    wait_cycles(14);

    // request held high across release, long enough to saturate the counter
    @(negedge clk);
    #2 sw_rst_req_i = 1'b1;
    rst_n_i = 1'b0;
    rst_events++;
    wait_cycles(2);
    #2 rst_n_i = 1'b1;
    wait_cycles(310 * 17);
    @(negedge clk);
    #2 sw_rst_req_i = 1'b0;
    wait_cycles(20);
    check("sat_cnt", 32'(sw_rst_cnt_o), 32'd255);

    // short reset pulse between stage 0 and stage 1 releases
    @(negedge clk);
    #2 rst_n_i = 1'b0;
    rst_events++;
    @(negedge clk);
    #2 rst_n_i = 1'b1;
    repeat (6) @(negedge clk);
    #1 check("midrel_pre", 32'(rst_n_o), 32'h1);
    #1 rst_n_i = 1'b0;
    rst_events++;
    #1 check_cleared("midrel");
    #2 rst_n_i = 1'b1;
    wait_cycles(16);

    wait_cycles(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
